sprite_frame_scheduler: RTL
===========================

Name: sprite_frame_scheduler

Overview:
Sequences all sprite-position updates into the display datapath so that sprite positions only change at frame boundaries. Two requesters share one write path into a shadow register bank through a round-robin req/ack arbiter: the local player tracker and the opponent link receiver. The shadow bank is committed atomically to the display-facing position registers on nf_in. The block also tracks opponent liveness, so a dead link hides the opponent instead of freezing its sprites on screen.

Parameters:
FIELD_W, 960, playfield width; x coordinates clamp to FIELD_W-1.
FIELD_H, 640, playfield height; y coordinates clamp to FIELD_H-1.
STALE_FRAMES, 30, frames without an opponent write before the opponent is declared stale (range 1..255).

Ports:
clk_in  input  1  system clock.
rst_in  input  1  asynchronous, active-high reset.
nf_in  input  1  new-frame strobe, one cycle wide.
p_req_in  input  1  player update request.
p_sel_in  input  2  player target: 0 BOX_MIN, 1 BOX_MAX, 2 SABER, 3 reserved.
p_x_in  input  12  player x value.
p_y_in  input  11  player y value.
p_ack_out  output  1  player ack pulse.
o_req_in, o_sel_in, o_x_in, o_y_in, o_ack_out  same widths and meaning, opponent requester.
player_box_x_out / player_box_y_out  output  12/11  committed player box minimum corner.
player_box_xmax_out / player_box_ymax_out  output  12/11  committed player box maximum corner.
player_saber_x_out / player_saber_y_out  output  12/11  committed player saber position.
opponent_box_x_out, opponent_box_y_out, opponent_box_xmax_out, opponent_box_ymax_out, opponent_saber_x_out, opponent_saber_y_out  output  12/11 each  committed opponent positions, same layout as the player outputs.
opp_valid_out  output  1  opponent sprites should be drawn.
opp_stale_out  output  1  opponent link stale.
err_out  output  1  one-cycle pulse on a reserved sel or a rejected box commit.

Behaviour:
- Reset (asynchronous):
  - All position outputs, the shadow bank, acks, err_out, opp_valid_out and opp_stale_out are 0.
  - Round-robin pointer points to the player.
  - Opponent "seen" flag and stale counter are 0.
- Handshake:
  - A requester holds req, sel, x and y stable until it sees ack high.
  - ack is a registered one-cycle pulse. The shadow write happens on the same edge ack rises.
  - A requester whose ack is currently high is ineligible that cycle, so there is no double write. Maximum rate per requester is one write every 2 cycles.
- Arbitration:
  - At most one grant per cycle.
  - With a single eligible requester, grant it.
  - With both eligible, grant the one the pointer selects, then flip the pointer to the other requester.
  - The pointer only changes on a contested grant.
- Write path:
  - x is clamped to min(x, FIELD_W-1) and y to min(y, FIELD_H-1) before the shadow write.
  - sel=3 is acked, writes nothing, and pulses err_out.
  - A granted opponent write sets the seen flag and sets an internal o_wrote flag for the current frame.
- Commit, on the edge where nf_in is sampled high:
  - Each requester's shadow set is copied to its outputs.
  - Box check, per requester: if shadow xmax < x or ymax < y, that requester's box outputs keep their old values, its saber still commits, and err_out pulses.
  - A write granted in the same cycle as nf_in lands in the shadow after the copy. It becomes visible at the next nf_in, not the current one.
- Staleness, evaluated at each nf_in:
  - If o_wrote is set: counter clears to 0.
  - Otherwise: counter increments, saturating at STALE_FRAMES.
  - o_wrote clears at every nf_in.
  - opp_stale_out = (counter == STALE_FRAMES).
  - opp_valid_out = seen & ~opp_stale_out. It is registered and updates on the commit edge.
- Latency: output change lags nf_in by 0 cycles (the same edge), and lags a write by 1 to N frames.
- Error pulses: if both err sources occur in one cycle, err_out is still a single pulse.
- Reset mid-frame: all shadow contents and the outputs clear. Pending requests are not acked until after reset deasserts.

Decomposition:
- Shared package disp_pkg:
  - sel_t enum {SEL_BOX_MIN, SEL_BOX_MAX, SEL_SABER, SEL_RSVD};
  - pos_t struct {x[11:0], y[11:0]... x 12 bits, y 11 bits};
  - sprite_set_t struct {box_min, box_max, saber};
  - FIELD_W and FIELD_H defaults.
- One sub-module: rr_arbiter2. It takes two req/eligible inputs and produces a one-hot grant plus the pointer update.
- Clamp, commit and staleness logic stay in the top module.

Test Plan:
- Player writes BOX_MIN (100,200), BOX_MAX (150,300), SABER (400,50) mid-frame -> all outputs stay 0 until nf_in. On the nf_in edge: player_box_x=100, ymax=300, saber_x=400.
- Both reqs held continuously, 6 writes each -> acks alternate player/opponent fairly, each ack a single-cycle pulse, never 2 player acks within 2 cycles.
- Opponent writes SABER (2000,1000) -> after nf_in, opponent_saber_x=959, y=639.
- Player BOX_MIN (500,500), BOX_MAX (400,600), then nf_in -> box outputs unchanged, saber committed, err_out pulses once.
- Opponent write lands in the same cycle as nf_in -> not visible at that frame, visible at the next nf_in.
- Opponent writes once, then 30 frames with no writes (STALE_FRAMES=30) -> opp_valid_out=1 after the first commit, opp_stale_out=1 and opp_valid_out=0 at the 30th silent nf_in. One new write plus nf_in -> valid=1, stale=0.

Source files
------------

// File: rtl/disp_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : disp_pkg
//  Description : Shared types, widths and helpers for the sprite frame
//                scheduler (position structs, target select, clamp, box check).
//  Revision    : 1.0 - initial release
// ============================================================================
package disp_pkg;

  localparam int X_W         = 12;
  localparam int Y_W         = 11;
  localparam int FIELD_W_DEF = 960;
  localparam int FIELD_H_DEF = 640;

  typedef enum logic [1:0] {
    SEL_BOX_MIN = 2'd0,
    SEL_BOX_MAX = 2'd1,
    SEL_SABER   = 2'd2,
    SEL_RSVD    = 2'd3
  } sel_t;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } pos_t;

  typedef struct packed {
    pos_t box_min;
    pos_t box_max;
    pos_t saber;
  } sprite_set_t;

  // Saturate a raw coordinate pair onto the visible playfield.
  function automatic pos_t clamp_pos(input logic [X_W-1:0] x,
                                     input logic [Y_W-1:0] y,
                                     input logic [X_W-1:0] x_max,
                                     input logic [Y_W-1:0] y_max);
    pos_t p;
    p.x = (x > x_max) ? x_max : x;
    p.y = (y > y_max) ? y_max : y;
    return p;
  endfunction

  // A box whose max corner lies left of or above its min corner is malformed.
  function automatic logic box_bad(input sprite_set_t s);
    return (s.box_max.x < s.box_min.x) || (s.box_max.y < s.box_min.y);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sprite_frame_scheduler_rr_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter2
//  Description : Two-requester round-robin arbiter. A requester whose ack is
//                currently high is not eligible. The pointer flips only when
//                both requesters are eligible in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2 (
  input  logic [1:0] req_i,    // bit 0 player, bit 1 opponent
  input  logic [1:0] busy_i,   // ack currently high for that requester
  input  logic       ptr_i,    // 0: player wins a contest, 1: opponent wins
  output logic [1:0] grant_o,  // one-hot or zero
  output logic       ptr_o     // pointer value for the next cycle
);

  logic [1:0] elig;

  assign elig = req_i & ~busy_i;

  // Grant the lone eligible requester, or the pointer's pick on a contest.
  always_comb begin
    grant_o = 2'b00;
    ptr_o   = ptr_i;
    if (elig == 2'b11) begin
      grant_o = ptr_i ? 2'b10 : 2'b01;
      ptr_o   = ~ptr_i;
    end else begin
      grant_o = elig;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sprite_frame_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_frame_scheduler
//  Description : Funnels player and opponent position updates through a
//                round-robin req/ack write port into a shadow bank, commits
//                the bank to the display registers on each new-frame strobe,
//                and tracks opponent link liveness.
//  Revision    : 1.0 - initial release
// ============================================================================
module sprite_frame_scheduler
  import disp_pkg::*;
#(
  parameter int FIELD_W      = FIELD_W_DEF,
  parameter int FIELD_H      = FIELD_H_DEF,
  parameter int STALE_FRAMES = 30
) (
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic           nf_in,
  input  logic           p_req_in,
  input  logic [1:0]     p_sel_in,
  input  logic [X_W-1:0] p_x_in,
  input  logic [Y_W-1:0] p_y_in,
  output logic           p_ack_out,
  input  logic           o_req_in,
  input  logic [1:0]     o_sel_in,
  input  logic [X_W-1:0] o_x_in,
  input  logic [Y_W-1:0] o_y_in,
  output logic           o_ack_out,
  output logic [X_W-1:0] player_box_x_out,
  output logic [Y_W-1:0] player_box_y_out,
  output logic [X_W-1:0] player_box_xmax_out,
  output logic [Y_W-1:0] player_box_ymax_out,
  output logic [X_W-1:0] player_saber_x_out,
  output logic [Y_W-1:0] player_saber_y_out,
  output logic [X_W-1:0] opponent_box_x_out,
  output logic [Y_W-1:0] opponent_box_y_out,
  output logic [X_W-1:0] opponent_box_xmax_out,
  output logic [Y_W-1:0] opponent_box_ymax_out,
  output logic [X_W-1:0] opponent_saber_x_out,
  output logic [Y_W-1:0] opponent_saber_y_out,
  output logic           opp_valid_out,
  output logic           opp_stale_out,
  output logic           err_out
);

  localparam logic [X_W-1:0] X_MAX     = X_W'(FIELD_W - 1);
  localparam logic [Y_W-1:0] Y_MAX     = Y_W'(FIELD_H - 1);
  localparam logic [7:0]     STALE_MAX = 8'(STALE_FRAMES);

  logic        p_ack_q, o_ack_q;
  logic        ptr_q, ptr_d;
  logic [1:0]  grant;
  sprite_set_t p_shadow_q, p_shadow_d, o_shadow_q, o_shadow_d;
  sprite_set_t p_out_q, p_out_d, o_out_q, o_out_d;
  logic        err_q, err_d;
  logic        seen_q, seen_d;
  logic        o_wrote_q, o_wrote_d;
  logic [7:0]  stale_cnt_q, stale_cnt_d;
  logic        valid_q, valid_d;

  rr_arbiter2 u_arb (
    .req_i   ({o_req_in, p_req_in}),
    .busy_i  ({o_ack_q, p_ack_q}),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .ptr_o   (ptr_d)
  );

  // Frame commit first (from the pre-write shadow), then the granted write;
  // a write in the nf_in cycle therefore only reaches the next frame.
  always_comb begin
    p_shadow_d = p_shadow_q;
    o_shadow_d = o_shadow_q;
    p_out_d    = p_out_q;
    o_out_d    = o_out_q;
    err_d      = 1'b0;

    if (nf_in) begin
      p_out_d.saber = p_shadow_q.saber;
      o_out_d.saber = o_shadow_q.saber;
      if (box_bad(p_shadow_q)) begin
        err_d = 1'b1;
      end else begin
        p_out_d.box_min = p_shadow_q.box_min;
        p_out_d.box_max = p_shadow_q.box_max;
      end
      if (box_bad(o_shadow_q)) begin
        err_d = 1'b1;
      end else begin
        o_out_d.box_min = o_shadow_q.box_min;
        o_out_d.box_max = o_shadow_q.box_max;
      end
    end

    if (grant[0]) begin
      case (sel_t'(p_sel_in))
        SEL_BOX_MIN: p_shadow_d.box_min = clamp_pos(p_x_in, p_y_in, X_MAX, Y_MAX);
        SEL_BOX_MAX: p_shadow_d.box_max = clamp_pos(p_x_in, p_y_in, X_MAX, Y_MAX);
        SEL_SABER:   p_shadow_d.saber   = clamp_pos(p_x_in, p_y_in, X_MAX, Y_MAX);
        default:     err_d              = 1'b1;
      endcase
    end

    if (grant[1]) begin
      case (sel_t'(o_sel_in))
        SEL_BOX_MIN: o_shadow_d.box_min = clamp_pos(o_x_in, o_y_in, X_MAX, Y_MAX);
        SEL_BOX_MAX: o_shadow_d.box_max = clamp_pos(o_x_in, o_y_in, X_MAX, Y_MAX);
        SEL_SABER:   o_shadow_d.saber   = clamp_pos(o_x_in, o_y_in, X_MAX, Y_MAX);
        default:     err_d              = 1'b1;
      endcase
    end
  end

  // Opponent liveness: any granted opponent request counts as link activity;
  // one granted in the nf_in cycle counts toward the following frame.
  always_comb begin
    seen_d      = seen_q | grant[1];
    o_wrote_d   = o_wrote_q;
    stale_cnt_d = stale_cnt_q;
    valid_d     = valid_q;
    if (nf_in) begin
      o_wrote_d = 1'b0;
      if (o_wrote_q) begin
        stale_cnt_d = 8'd0;
      end else if (stale_cnt_q != STALE_MAX) begin
        stale_cnt_d = stale_cnt_q + 8'd1;
      end
      valid_d = seen_q & (stale_cnt_d != STALE_MAX);
    end
    if (grant[1]) begin
      o_wrote_d = 1'b1;
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      p_ack_q     <= 1'b0;
      o_ack_q     <= 1'b0;
      ptr_q       <= 1'b0;
      p_shadow_q  <= '0;
      o_shadow_q  <= '0;
      p_out_q     <= '0;
      o_out_q     <= '0;
      err_q       <= 1'b0;
      seen_q      <= 1'b0;
      o_wrote_q   <= 1'b0;
      stale_cnt_q <= 8'd0;
      valid_q     <= 1'b0;
    end else begin
      p_ack_q     <= grant[0];
      o_ack_q     <= grant[1];
      ptr_q       <= ptr_d;
      p_shadow_q  <= p_shadow_d;
      o_shadow_q  <= o_shadow_d;
      p_out_q     <= p_out_d;
      o_out_q     <= o_out_d;
      err_q       <= err_d;
      seen_q      <= seen_d;
      o_wrote_q   <= o_wrote_d;
      stale_cnt_q <= stale_cnt_d;
      valid_q     <= valid_d;
    end
  end

  assign p_ack_out             = p_ack_q;
  assign o_ack_out             = o_ack_q;
  assign err_out               = err_q;
  assign opp_valid_out         = valid_q;
  assign opp_stale_out         = (stale_cnt_q == STALE_MAX);
  assign player_box_x_out      = p_out_q.box_min.x;
  assign player_box_y_out      = p_out_q.box_min.y;
  assign player_box_xmax_out   = p_out_q.box_max.x;
  assign player_box_ymax_out   = p_out_q.box_max.y;
  assign player_saber_x_out    = p_out_q.saber.x;
  assign player_saber_y_out    = p_out_q.saber.y;
  assign opponent_box_x_out    = o_out_q.box_min.x;
  assign opponent_box_y_out    = o_out_q.box_min.y;
  assign opponent_box_xmax_out = o_out_q.box_max.x;
  assign opponent_box_ymax_out = o_out_q.box_max.y;
  assign opponent_saber_x_out  = o_out_q.saber.x;
  assign opponent_saber_y_out  = o_out_q.saber.y;

endmodule
`default_nettype wire
